// File: rtl/fir_frame_ctrl.sv
// Frame sequencer and coefficient bank for the 5x5 systolic FIR.
// Buffers four previous lines and presents a vertical 5-pixel window per accepted pixel.
module fir_frame_ctrl #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   s_pixel,
    input  logic         s_valid,
    input  logic         s_sof,
    output logic         s_ready,
    output logic [7:0]   win_pixel0,
    output logic [7:0]   win_pixel1,
    output logic [7:0]   win_pixel2,
    output logic [7:0]   win_pixel3,
    output logic [7:0]   win_pixel4,
    output logic         win_valid,
    input  logic         coef_we,
    input  logic [4:0]   coef_addr,
    input  logic [15:0]  coef_data,
    output logic [399:0] coeff_flat,
    output logic         coef_busy,
    input  logic         f_out_valid,
    output logic         frame_done,
    output logic         sof_err,
    output logic [1:0]   state
);

    localparam int XW    = $clog2(IMG_WIDTH);
    localparam int YW    = $clog2(IMG_HEIGHT);
    localparam int TOTAL = (IMG_HEIGHT - 4) * IMG_WIDTH;
    localparam int OW    = $clog2(TOTAL + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;
    logic [OW-1:0] out_cnt;
    logic [1:0]    state_nxt;
    logic [15:0]   coef [0:24];
    logic [7:0]    lb0 [0:IMG_WIDTH-1];
    logic [7:0]    lb1 [0:IMG_WIDTH-1];
    logic [7:0]    lb2 [0:IMG_WIDTH-1];
    logic [7:0]    lb3 [0:IMG_WIDTH-1];

    // Handshake: a pixel transfers on any rising edge where s_valid and s_ready are both 1;
    // s_ready depends only on registered state, never on s_valid.
    logic accept, in_frame, start, frame_acc, store, last_col;
    logic [XW-1:0] wr_x;

    assign s_ready   = (state != ST_DRAIN);
    assign accept    = s_valid & s_ready;
    assign in_frame  = (state == ST_FILL) || (state == ST_RUN);
    assign start     = accept & s_sof;
    assign frame_acc = accept & in_frame & ~s_sof;
    assign store     = start | frame_acc;
    assign last_col  = (x_cnt == XW'(IMG_WIDTH - 1));
    assign wr_x      = s_sof ? '0 : x_cnt;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_FILL;
            ST_FILL: begin
                if (start)
                    state_nxt = ST_FILL;
                else if (frame_acc && last_col && y_cnt == YW'(3))
                    state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (start)
                    state_nxt = ST_FILL;
                else if (frame_acc && last_col && y_cnt == YW'(IMG_HEIGHT - 1))
                    state_nxt = ST_DRAIN;
            end
            default:  if (frame_done) state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            coef_busy <= 1'b0;
            x_cnt     <= '0;
            y_cnt     <= '0;
            out_cnt   <= '0;
            sof_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            coef_busy <= (state_nxt != ST_IDLE);
            sof_err   <= start & in_frame;
            if (start) begin
                x_cnt <= XW'(1);
                y_cnt <= '0;
            end else if (frame_acc) begin
                if (last_col) begin
                    x_cnt <= '0;
                    y_cnt <= (y_cnt == YW'(IMG_HEIGHT - 1)) ? '0 : y_cnt + YW'(1);
                end else begin
                    x_cnt <= x_cnt + XW'(1);
                end
            end
            // Saturates at TOTAL so surplus filter pulses cannot wrap the count.
            if (start || (state == ST_DRAIN && frame_done))
                out_cnt <= '0;
            else if ((state == ST_RUN || state == ST_DRAIN) && f_out_valid &&
                     out_cnt != OW'(TOTAL))
                out_cnt <= out_cnt + OW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            frame_done <= 1'b0;
        else
            frame_done <= (state == ST_DRAIN) && !frame_done &&
                          ((out_cnt == OW'(TOTAL)) ||
                           (f_out_valid && out_cnt == OW'(TOTAL - 1)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_valid  <= 1'b0;
            win_pixel0 <= '0;
            win_pixel1 <= '0;
            win_pixel2 <= '0;
            win_pixel3 <= '0;
            win_pixel4 <= '0;
        end else begin
            win_valid <= frame_acc && (state == ST_RUN);
            if (frame_acc && state == ST_RUN) begin
                win_pixel0 <= lb3[wr_x];
                win_pixel1 <= lb2[wr_x];
                win_pixel2 <= lb1[wr_x];
                win_pixel3 <= lb0[wr_x];
                win_pixel4 <= s_pixel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (store) begin
            lb3[wr_x] <= lb2[wr_x];
            lb2[wr_x] <= lb1[wr_x];
            lb1[wr_x] <= lb0[wr_x];
            lb0[wr_x] <= s_pixel;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 25; i++)
                coef[i] <= (i == 12) ? 16'h0100 : 16'h0000;
        end else if (state == ST_IDLE && coef_we && coef_addr < 5'd25) begin
            coef[coef_addr] <= coef_data;
        end
    end

    for (genvar i = 0; i < 25; i++) begin : g_flat
        assign coeff_flat[i*16 +: 16] = coef[i];
    end

endmodule

// File: tb/tb_fir_frame_ctrl.sv
// Directed bench for fir_frame_ctrl with an 8x6 frame: windows, draining, coefficients,
// mid-frame sof and mid-frame reset.
module tb_fir_frame_ctrl;

    localparam int W = 8;
    localparam int H = 6;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [7:0]   s_pixel = '0;
    logic         s_valid = 1'b0;
    logic         s_sof = 1'b0;
    logic         s_ready;
    logic [7:0]   win_pixel0, win_pixel1, win_pixel2, win_pixel3, win_pixel4;
    logic         win_valid;
    logic         coef_we = 1'b0;
    logic [4:0]   coef_addr = '0;
    logic [15:0]  coef_data = '0;
    logic [399:0] coeff_flat;
    logic         coef_busy;
    logic         f_out_valid = 1'b0;
    logic         frame_done;
    logic         sof_err;
    logic [1:0]   state;

    int checks = 0;
    int failures = 0;
    logic [39:0]  win_q[$];
    logic [39:0]  exp_q[$];
    logic [399:0] exp_coef;

    fir_frame_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst(rst),
        .s_pixel(s_pixel), .s_valid(s_valid), .s_sof(s_sof), .s_ready(s_ready),
        .win_pixel0(win_pixel0), .win_pixel1(win_pixel1), .win_pixel2(win_pixel2),
        .win_pixel3(win_pixel3), .win_pixel4(win_pixel4), .win_valid(win_valid),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .coeff_flat(coeff_flat), .coef_busy(coef_busy),
        .f_out_valid(f_out_valid), .frame_done(frame_done), .sof_err(sof_err),
        .state(state)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (win_valid) win_q.push_back({win_pixel0, win_pixel1, win_pixel2, win_pixel3, win_pixel4});

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [399:0] obs, input logic [399:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] p, input logic sof, input logic fov);
        @(negedge clk);
        s_valid = 1'b1; s_pixel = p; s_sof = sof; f_out_valid = fov;
        @(posedge clk); #1;
        s_valid = 1'b0; s_sof = 1'b0; f_out_valid = 1'b0;
    endtask

    task automatic gap();
        @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic wr_coef(input logic [4:0] a, input logic [15:0] d);
        @(negedge clk);
        coef_we = 1'b1; coef_addr = a; coef_data = d;
        @(posedge clk); #1;
        coef_we = 1'b0;
    endtask

    // Expected windows for a frame whose pixel (x,y) carries value off + y*W + x.
    task automatic build_exp(input int off);
        exp_q.delete();
        for (int k = 0; k < (H - 4) * W; k++) begin
            int x, y;
            logic [7:0] p0, p1, p2, p3, p4;
            x = k % W; y = 4 + k / W;
            p0 = 8'(off + (y - 4) * W + x);
            p1 = 8'(off + (y - 3) * W + x);
            p2 = 8'(off + (y - 2) * W + x);
            p3 = 8'(off + (y - 1) * W + x);
            p4 = 8'(off + y * W + x);
            exp_q.push_back({p0, p1, p2, p3, p4});
        end
    endtask

    task automatic drain_and_check(input string tag);
        for (int i = 0; i < (H - 4) * W; i++) begin
            @(negedge clk);
            if (i == (H - 4) * W - 1) chk({tag, "_done_early"}, 400'(frame_done), 400'(0));
            f_out_valid = 1'b1;
        end
        @(negedge clk);
        f_out_valid = 1'b0;
        chk({tag, "_done_pulse"}, 400'(frame_done), 400'(1));
        chk({tag, "_ready_low"}, 400'(s_ready), 400'(0));
        @(negedge clk);
        chk({tag, "_done_clear"}, 400'(frame_done), 400'(0));
        chk({tag, "_idle"}, 400'(state), 400'(0));
        chk({tag, "_ready_high"}, 400'(s_ready), 400'(1));
        chk({tag, "_win_count"}, 400'(win_q.size()), 400'(exp_q.size()));
        while (exp_q.size() > 0 && win_q.size() > 0)
            chk({tag, "_window"}, 400'(win_q.pop_front()), 400'(exp_q.pop_front()));
        win_q.delete();
    endtask

    initial begin
        exp_coef = '0;
        exp_coef[12*16 +: 16] = 16'h0100;

        #12;
        chk("rst_state", 400'(state), 400'(0));
        chk("rst_ready", 400'(s_ready), 400'(1));
        chk("rst_outs", 400'({win_valid, frame_done, sof_err, coef_busy}), 400'(0));
        chk("rst_coef", coeff_flat, exp_coef);
        @(negedge clk);
        rst = 1'b1;

        wr_coef(5'd3, 16'hFF80);
        exp_coef[63:48] = 16'hFF80;
        chk("coef_wr3", 400'(coeff_flat[63:48]), 400'(16'hFF80));
        wr_coef(5'd27, 16'h1234);
        chk("coef_wr27_ignored", coeff_flat, exp_coef);

        for (int i = 0; i < 5; i++) send(8'(200 + i), 1'b0, 1'b0);
        chk("idle_discard_state", 400'(state), 400'(0));
        chk("idle_discard_win", 400'(win_q.size()), 400'(0));

        // Continuous frame; filter pulses during IDLE/FILL must not count.
        build_exp(0);
        for (int i = 0; i < W * H; i++) begin
            send(8'(i), i == 0, i < W);
            if (i == 0) chk("f1_fill", 400'(state), 400'(1));
            if (i == 4 * W - 1) chk("f1_run", 400'(state), 400'(2));
        end
        chk("f1_drain", 400'(state), 400'(3));
        chk("f1_busy", 400'(coef_busy), 400'(1));
        drain_and_check("f1");

        // Frame with random gaps and a coefficient write attempt during RUN.
        build_exp(0);
        for (int i = 0; i < W * H; i++) begin
            if ($urandom_range(0, 1) == 1) gap();
            if (i == 40) begin
                wr_coef(5'd3, 16'h1111);
                chk("run_busy", 400'(coef_busy), 400'(1));
                chk("run_coef_ignored", coeff_flat, exp_coef);
            end
            send(8'(i), i == 0, 1'b0);
        end
        drain_and_check("f2");

        // Unexpected sof at (x=3, y=4) after three counted filter outputs.
        for (int i = 0; i < 4 * W + 3; i++) send(8'(i), i == 0, i >= 4 * W);
        send(8'(50), 1'b1, 1'b0);
        chk("sof_err_pulse", 400'(sof_err), 400'(1));
        chk("sof_err_fill", 400'(state), 400'(1));
        chk("sof_old_windows", 400'(win_q.size()), 400'(3));
        win_q.delete();
        build_exp(50);
        for (int i = 1; i < W * H; i++) begin
            send(8'(50 + i), 1'b0, 1'b0);
            if (i == 1) chk("sof_err_clear", 400'(sof_err), 400'(0));
        end
        drain_and_check("f3");

        // Reset asserted in RUN.
        for (int i = 0; i < 5 * W; i++) send(8'(i), i == 0, 1'b0);
        chk("pre_rst_run", 400'(state), 400'(2));
        rst = 1'b0;
        #1;
        exp_coef = '0;
        exp_coef[12*16 +: 16] = 16'h0100;
        chk("mid_rst_state", 400'(state), 400'(0));
        chk("mid_rst_win", 400'({win_valid, win_pixel0, win_pixel1, win_pixel2, win_pixel3, win_pixel4}), 400'(0));
        chk("mid_rst_flags", 400'({frame_done, sof_err, coef_busy}), 400'(0));
        chk("mid_rst_coef", coeff_flat, exp_coef);
        s_valid = 1'b1; s_sof = 1'b1;
        @(negedge clk);
        chk("held_rst_state", 400'(state), 400'(0));
        chk("held_rst_ready", 400'(s_ready), 400'(1));
        s_valid = 1'b0; s_sof = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) send(8'(i), 1'b0, 1'b0);
        chk("post_rst_needs_sof", 400'(state), 400'(0));
        chk("post_rst_ready", 400'(s_ready), 400'(1));
        send(8'(0), 1'b1, 1'b0);
        chk("post_rst_sof", 400'(state), 400'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
